// File: rtl/nx_dot_pkg.sv
// Shared types and widths for the 6-lane int8 dot-product sequencer.
package nx_dot_pkg;

   localparam int unsigned DOT6_LANES = 6;
   localparam int unsigned DOT6_IN_W  = 8;
   localparam int unsigned DOT6_RES_W = 19;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} dot_seq_state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } dot_tag_t;

endpackage

// File: rtl/nx_dot_tag_pipe.sv
// Shadow tag pipeline: DEPTH-stage shift register of chunk tags, cleared by synchronous active-low reset.
module nx_dot_tag_pipe
   import nx_dot_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  dot_tag_t tag_i,
   output dot_tag_t tag_o
);

   dot_tag_t stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nx_dot6_seq_ctrl.sv
// Streams 6-lane int8 chunks into an external pipelined dot unit and accumulates one result per vector.
// Define NX_DOT_SEQ_SAT_EN for a saturating accumulator with a sticky sat_flag output.
module nx_dot6_seq_ctrl
   import nx_dot_pkg::*;
#(
   parameter int unsigned DOT_LAT    = 2,
   parameter int unsigned MAX_CHUNKS = 256,
   parameter int unsigned CNT_W      = $clog2(MAX_CHUNKS + 1),
   parameter int unsigned ACC_W      = 24
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [CNT_W-1:0]                  cfg_num_chunks,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DOT6_LANES*DOT6_IN_W-1:0]   in_a,
   input  logic [DOT6_LANES*DOT6_IN_W-1:0]   in_b,
   output logic [DOT6_LANES*DOT6_IN_W-1:0]   dot_a,
   output logic [DOT6_LANES*DOT6_IN_W-1:0]   dot_b,
   input  logic [DOT6_RES_W-1:0]             dot_res,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ACC_W-1:0]                  out_data,
   output logic                              busy
`ifdef NX_DOT_SEQ_SAT_EN
   ,
   output logic                              sat_flag
`endif
);

   localparam int unsigned VEC_W = DOT6_LANES * DOT6_IN_W;

   dot_seq_state_t          state_q, state_d;
   logic [CNT_W-1:0]        n_q, n_d;
   logic [CNT_W-1:0]        issued_q, issued_d;
   logic [CNT_W-1:0]        issued_inc;
   logic [CNT_W-1:0]        n_sel;
   logic [VEC_W-1:0]        dot_a_q, dot_a_d;
   logic [VEC_W-1:0]        dot_b_q, dot_b_d;
   dot_tag_t                tag_q, tag_d;
   dot_tag_t                tap;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] res_ext;
   logic [ACC_W-1:0]        out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    accept;
`ifdef NX_DOT_SEQ_SAT_EN
   logic                    sat_q, sat_d;
   logic                    acc_clamp;
   logic signed [ACC_W:0]   sum_w;
`endif

   // Zero chunks is treated as one; oversized requests clamp to the supported maximum.
   assign n_sel = (cfg_num_chunks == '0)                 ? CNT_W'(1) :
                  (cfg_num_chunks > CNT_W'(MAX_CHUNKS))  ? CNT_W'(MAX_CHUNKS) :
                                                           cfg_num_chunks;

   assign issued_inc = issued_q + CNT_W'(1);
   assign in_ready   = (state_q == IDLE) || (state_q == ISSUE);
   assign accept     = in_valid && in_ready;
   assign res_ext    = ACC_W'(signed'(dot_res));

   // Tag register sits alongside dot_a/dot_b; the pipe adds DOT_LAT more stages so its tail lines up with dot_res.
   nx_dot_tag_pipe #(
      .DEPTH (DOT_LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .tag_i (tag_q),
      .tag_o (tap)
   );

`ifdef NX_DOT_SEQ_SAT_EN
   always_comb begin
      sum_w     = {acc_q[ACC_W-1], acc_q} + {res_ext[ACC_W-1], res_ext};
      acc_next  = sum_w[ACC_W-1:0];
      acc_clamp = 1'b0;
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
         acc_clamp = 1'b1;
         acc_next  = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   always_comb begin
      acc_next = acc_q + res_ext;
   end
`endif

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      issued_d    = issued_q;
      dot_a_d     = dot_a_q;
      dot_b_d     = dot_b_q;
      tag_d       = '0;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef NX_DOT_SEQ_SAT_EN
      sat_d       = sat_q;
`endif

      if (tap.valid) begin
         acc_d = acc_next;
`ifdef NX_DOT_SEQ_SAT_EN
         sat_d = sat_q | acc_clamp;
`endif
         if (tap.last) begin
            out_data_d  = acc_next;
            out_valid_d = 1'b1;
            state_d     = OUTPUT;
         end
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               n_d         = n_sel;
               issued_d    = CNT_W'(1);
               dot_a_d     = in_a;
               dot_b_d     = in_b;
               tag_d.valid = 1'b1;
               tag_d.last  = (n_sel == CNT_W'(1));
               acc_d       = '0;
`ifdef NX_DOT_SEQ_SAT_EN
               sat_d       = 1'b0;
`endif
               state_d     = (n_sel == CNT_W'(1)) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               issued_d    = issued_inc;
               dot_a_d     = in_a;
               dot_b_d     = in_b;
               tag_d.valid = 1'b1;
               tag_d.last  = (issued_inc == n_q);
               if (issued_inc == n_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
         end
         OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         n_q         <= '0;
         issued_q    <= '0;
         dot_a_q     <= '0;
         dot_b_q     <= '0;
         tag_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef NX_DOT_SEQ_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         issued_q    <= issued_d;
         dot_a_q     <= dot_a_d;
         dot_b_q     <= dot_b_d;
         tag_q       <= tag_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef NX_DOT_SEQ_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

   assign dot_a     = dot_a_q;
   assign dot_b     = dot_b_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != IDLE);
`ifdef NX_DOT_SEQ_SAT_EN
   assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_nx_dot6_seq_ctrl.sv
// Bench for nx_dot6_seq_ctrl with a behavioural dot unit and a vector-level reference model.
// Honours NX_DOT_SEQ_SAT_EN when defined for the whole build.
module tb_nx_dot6_seq_ctrl;

   localparam int unsigned DOT_LAT    = 2;
   localparam int unsigned MAX_CHUNKS = 256;
   localparam int unsigned CNT_W      = 9;
   localparam int unsigned ACC_W      = 24;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CNT_W-1:0] cfg_num_chunks;
   logic             in_valid;
   logic             in_ready;
   logic [47:0]      in_a, in_b;
   logic [47:0]      dot_a, dot_b;
   logic [18:0]      dot_res;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic             busy;
`ifdef NX_DOT_SEQ_SAT_EN
   logic             sat_flag;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [47:0] qa[$];
   logic [47:0] qb[$];

   bit          garbage_en;
   logic [18:0] dpipe [DOT_LAT];

   always #5 clk = ~clk;

   nx_dot6_seq_ctrl #(
      .DOT_LAT    (DOT_LAT),
      .MAX_CHUNKS (MAX_CHUNKS),
      .CNT_W      (CNT_W),
      .ACC_W      (ACC_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_num_chunks (cfg_num_chunks),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .dot_a          (dot_a),
      .dot_b          (dot_b),
      .dot_res        (dot_res),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .busy           (busy)
`ifdef NX_DOT_SEQ_SAT_EN
      ,
      .sat_flag       (sat_flag)
`endif
   );

   function automatic longint dot6(input logic [47:0] a, input logic [47:0] b);
      longint s = 0;
      for (int l = 0; l < 6; l++) begin
         s += longint'($signed(a[8*l +: 8])) * longint'($signed(b[8*l +: 8]));
      end
      return s;
   endfunction

   // Dot unit: DOT_LAT-deep pipeline, no reset; garbage while the bench powers up.
   always @(posedge clk) begin
      if (garbage_en) begin
         for (int i = 0; i < DOT_LAT; i++) dpipe[i] <= 19'($urandom);
      end else begin
         dpipe[0] <= 19'(dot6(dot_a, dot_b));
         for (int i = 1; i < DOT_LAT; i++) dpipe[i] <= dpipe[i-1];
      end
   end
   assign dot_res = dpipe[DOT_LAT-1];

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int eff_chunks(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > int'(MAX_CHUNKS)) return int'(MAX_CHUNKS);
      return cfg;
   endfunction

   function automatic longint model_sum(input int n);
      longint hi   = (longint'(1) <<< (ACC_W-1)) - 1;
      longint lo   = -(longint'(1) <<< (ACC_W-1));
      longint span = longint'(1) <<< ACC_W;
      longint acc  = 0;
      for (int i = 0; i < n; i++) begin
         acc += dot6(qa[i], qb[i]);
`ifdef NX_DOT_SEQ_SAT_EN
         if (acc > hi) acc = hi;
         else if (acc < lo) acc = lo;
`else
         while (acc > hi) acc -= span;
         while (acc < lo) acc += span;
`endif
      end
      return acc;
   endfunction

`ifdef NX_DOT_SEQ_SAT_EN
   function automatic longint model_sat(input int n);
      longint hi  = (longint'(1) <<< (ACC_W-1)) - 1;
      longint lo  = -(longint'(1) <<< (ACC_W-1));
      longint acc = 0;
      longint sat = 0;
      for (int i = 0; i < n; i++) begin
         acc += dot6(qa[i], qb[i]);
         if (acc > hi) begin acc = hi; sat = 1; end
         else if (acc < lo) begin acc = lo; sat = 1; end
      end
      return sat;
   endfunction
`endif

   task automatic fill_const(input int n, input logic [47:0] a, input logic [47:0] b);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin qa.push_back(a); qb.push_back(b); end
   endtask

   task automatic fill_rand(input int n);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
         qa.push_back(48'({$urandom, $urandom}));
         qb.push_back(48'({$urandom, $urandom}));
      end
   endtask

   task automatic run_vec(input int cfg, input int gap_after, input int gap_len,
                          input int hold, input string tag);
      int     n;
      longint exp_v;
      n     = eff_chunks(cfg);
      exp_v = model_sum(n);
      for (int i = 0; i < n; i++) begin
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               in_valid = 1'b0;
               in_a     = 48'({$urandom, $urandom});
               step();
               check_eq({tag, ".gap_ready"}, in_ready, 1);
            end
         end
         in_valid       = 1'b1;
         in_a           = qa[i];
         in_b           = qb[i];
         cfg_num_chunks = (i == 0) ? CNT_W'(cfg) : CNT_W'($urandom);
         check_eq({tag, ".in_ready"}, in_ready, 1);
         step();
         if (i == 0) check_eq({tag, ".dot_a0"}, dot_a, qa[0]);
      end
      // Keep offering junk while the vector drains; none of it may be taken.
      in_a = 48'({$urandom, $urandom});
      in_b = 48'({$urandom, $urandom});
      for (int k = 0; k <= int'(DOT_LAT); k++) begin
         check_eq({tag, ".lat_valid"}, out_valid, 0);
         check_eq({tag, ".drain_ready"}, in_ready, 0);
         check_eq({tag, ".drain_busy"}, busy, 1);
         step();
      end
      check_eq({tag, ".out_valid"}, out_valid, 1);
      check_eq({tag, ".out_data"}, longint'($signed(out_data)), exp_v);
      check_eq({tag, ".dot_a_hold"}, dot_a, qa[n-1]);
`ifdef NX_DOT_SEQ_SAT_EN
      check_eq({tag, ".sat_flag"}, sat_flag, model_sat(n));
`endif
      for (int h = 0; h < hold; h++) begin
         step();
         check_eq({tag, ".held_valid"}, out_valid, 1);
         check_eq({tag, ".held_data"}, longint'($signed(out_data)), exp_v);
         check_eq({tag, ".held_busy"}, busy, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_eq({tag, ".post_valid"}, out_valid, 0);
      check_eq({tag, ".post_busy"}, busy, 0);
      check_eq({tag, ".post_ready"}, in_ready, 1);
   endtask

   initial begin
      int n;
      garbage_en     = 1'b1;
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      in_a           = '0;
      in_b           = '0;
      cfg_num_chunks = '0;
      out_ready      = 1'b0;
      repeat (3) step();
      check_eq("rst.in_ready", in_ready, 1);
      check_eq("rst.out_valid", out_valid, 0);
      check_eq("rst.out_data", out_data, 0);
      check_eq("rst.busy", busy, 0);
      check_eq("rst.dot_a", dot_a, 0);
      check_eq("rst.dot_b", dot_b, 0);
`ifdef NX_DOT_SEQ_SAT_EN
      check_eq("rst.sat_flag", sat_flag, 0);
`endif
      rst_n      = 1'b1;
      garbage_en = 1'b0;
      step();

      fill_const(1, 48'h060504030201, 48'h010101010101);
      run_vec(1, -1, 0, 0, "single");

      fill_const(4, 48'h020202020202, 48'h030303030303);
      run_vec(4, -1, 0, 0, "stream");

      fill_rand(3);
      run_vec(3, 1, 2, 5, "gap_bp");

      fill_const(1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);
      run_vec(0, -1, 0, 1, "n0");

      fill_const(256, 48'h808080808080, 48'h808080808080);
      run_vec(256, -1, 0, 2, "ovf");

      fill_rand(256);
      run_vec(300, 7, 1, 0, "clamp");

      // Abort a 5-chunk vector after its second chunk while results are still in flight.
      fill_rand(5);
      for (int i = 0; i < 2; i++) begin
         in_valid       = 1'b1;
         in_a           = qa[i];
         in_b           = qb[i];
         cfg_num_chunks = CNT_W'(5);
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n    = 1'b1;
      check_eq("mid_rst.busy", busy, 0);
      check_eq("mid_rst.in_ready", in_ready, 1);
      check_eq("mid_rst.dot_a", dot_a, 0);
      for (int k = 0; k < int'(DOT_LAT) + 4; k++) begin
         check_eq("mid_rst.no_valid", out_valid, 0);
         step();
      end
      fill_const(1, 48'h010101010101, 48'h010101010101);
      run_vec(1, -1, 0, 0, "after_rst");

      for (int v = 0; v < 8; v++) begin
         n = int'($urandom_range(1, 12));
         fill_rand(n);
         run_vec(n, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
